basic_and_n: RTL and testbench
==============================

BASIC_AND_N -- requirements
Module: basic_and_n

Interface
REQ-001 SHALL have parameter N, default 2, number of input channels (legal 2..16).
REQ-002 SHALL have parameter MODE, default 0, evaluation function: 0 = AND, 1 = OR, 2 = XOR (odd parity of arrivals).
REQ-003 SHALL have parameter LATENCY, default 1, eval-to-out delay in clk cycles (legal 1..8).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  N  per-channel arrival pulses, one bit per channel, high for one cycle = one arrival.
REQ-007 SHALL have port eval  input  1  gate-clock strobe, high for one cycle = evaluate and clear.
REQ-008 SHALL have port out  output  1  result pulse, high for exactly one cycle per true evaluation.
REQ-009 SHALL have port armed  output  N  current latched-arrival vector, registered.
REQ-010 SHALL have port dup_err  output  1  sticky flag: a channel arrived twice within one evaluation window.

Function
REQ-011 SHALL latch in[i] into armed[i] on any cycle where in[i]=1 and eval=0; armed[i] holds until the next eval or rst.
REQ-012 SHALL on eval=1 compute the result over the effective vector E = armed | in (an arrival in the same cycle as eval belongs to the current evaluation).
REQ-013 SHALL compute result as: MODE 0 -> &E; MODE 1 -> |E; MODE 2 -> ^E.
REQ-014 SHALL clear armed to all zeros on the cycle after eval=1, regardless of result.
REQ-015 SHALL drive out=1 for exactly one cycle, LATENCY cycles after the eval cycle (eval in cycle t -> out in cycle t+LATENCY), when result=1; out=0 otherwise.
REQ-016 SHALL implement delay as a LATENCY-deep shift pipeline so evals on consecutive cycles produce independent out pulses on consecutive cycles.
REQ-017 SHALL treat eval with E = all zeros as a valid evaluation: result per MODE (AND -> 0, OR -> 0, XOR -> 0), out stays 0.
REQ-018 SHALL set dup_err=1 on the cycle after in[i]=1 while armed[i]=1 already and eval=0; dup_err remains 1 until rst.
REQ-019 SHALL not set dup_err when in[i]=1 coincides with eval=1 and armed[i]=1; the arrival is merged into the current evaluation and is not carried forward.
REQ-020 SHALL not carry any arrival across an evaluation: after the eval cycle armed reflects only arrivals from cycles strictly later than eval.
REQ-021 SHALL have no combinational path from any input to out, armed or dup_err.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, set armed=0, dup_err=0, out=0 and clear every pipeline stage on the following cycle.
REQ-023 SHALL discard in and eval on any cycle where rst=1; an eval in flight in the pipeline when rst asserts SHALL never produce an out pulse.
REQ-024 SHALL resume normal latching on the first cycle with rst=0.

Verification
REQ-025 SHALL pass: N=2, MODE=0, LATENCY=1; in[0] pulse cycle 2, in[1] pulse cycle 4, eval cycle 6 -> out=1 in cycle 7 only, armed=00 from cycle 7.
REQ-026 SHALL pass: N=2, MODE=0; in[0] pulse cycle 2, eval cycle 5 -> out=0 throughout; eval again cycle 8 with no arrivals -> out=0.
REQ-027 SHALL pass: N=4, MODE=2, LATENCY=3; in=0111 same cycle as eval at cycle 10 -> out=1 in cycle 13, armed stays 0000.
REQ-028 SHALL pass: N=2, MODE=1, LATENCY=2; in[1] cycle 1, eval cycles 3 and 4 with in[0] in cycle 4 -> out=1 in cycles 5 and 6.
REQ-029 SHALL pass: N=2, MODE=0; in[0] cycles 2 and 4, no eval -> dup_err=1 from cycle 5 and held; rst cycle 9 -> dup_err=0, armed=00 at cycle 10.
REQ-030 SHALL pass: N=2, MODE=0, LATENCY=4; both arrivals, eval cycle 10, rst cycle 12 -> no out pulse at cycle 14.

Source files
------------

// File: rtl/basic_and_n.sv
// Multi-input arrival gate: latches per-channel pulses, evaluates AND/OR/XOR on an eval strobe,
// and emits the result as a one-cycle pulse LATENCY cycles later through a shift pipeline.
module basic_and_n #(
  parameter int N       = 2,
  parameter int MODE    = 0,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         eval,
  output logic         out,
  output logic [N-1:0] armed,
  output logic         dup_err
);

  logic [N-1:0]       armed_q, armed_d;
  logic [N-1:0]       eff;
  logic               result;
  logic               dup_q, dup_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;

  always_comb begin
    // Same-cycle arrivals join the evaluation in progress instead of being carried forward.
    eff = armed_q | in;
    if (MODE == 0) begin
      result = &eff;
    end else if (MODE == 1) begin
      result = |eff;
    end else begin
      result = ^eff;
    end

    armed_d = eval ? '0 : (armed_q | in);
    dup_d   = dup_q | (~eval & (|(in & armed_q)));

    pipe_d    = pipe_q << 1;
    pipe_d[0] = eval & result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= '0;
      dup_q   <= 1'b0;
      pipe_q  <= '0;
    end else begin
      armed_q <= armed_d;
      dup_q   <= dup_d;
      pipe_q  <= pipe_d;
    end
  end

  assign out     = pipe_q[LATENCY-1];
  assign armed   = armed_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_basic_and_n.sv
// Scoreboard bench for basic_and_n: four parameterisations share one clock; eval results
// are queued with their due cycle when driven and compared when the pulse should appear.
module tb_basic_and_n;

  typedef struct {
    int   due;
    logic val;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: N=2 AND L=1, B: N=4 XOR L=3, C: N=2 OR L=2, D: N=2 AND L=4
  logic       rstA = 1'b1, evalA = 1'b0, outA, dupA;
  logic [1:0] inA = '0, armedA;
  logic       rstB = 1'b1, evalB = 1'b0, outB, dupB;
  logic [3:0] inB = '0, armedB;
  logic       rstC = 1'b1, evalC = 1'b0, outC, dupC;
  logic [1:0] inC = '0, armedC;
  logic       rstD = 1'b1, evalD = 1'b0, outD, dupD;
  logic [1:0] inD = '0, armedD;

  int  total  = 0;
  int  passed = 0;
  sb_t sb[$];

  basic_and_n #(.N(2), .MODE(0), .LATENCY(1)) dutA (
    .clk(clk), .rst(rstA), .in(inA), .eval(evalA), .out(outA), .armed(armedA), .dup_err(dupA));
  basic_and_n #(.N(4), .MODE(2), .LATENCY(3)) dutB (
    .clk(clk), .rst(rstB), .in(inB), .eval(evalB), .out(outB), .armed(armedB), .dup_err(dupB));
  basic_and_n #(.N(2), .MODE(1), .LATENCY(2)) dutC (
    .clk(clk), .rst(rstC), .in(inC), .eval(evalC), .out(outC), .armed(armedC), .dup_err(dupC));
  basic_and_n #(.N(2), .MODE(0), .LATENCY(4)) dutD (
    .clk(clk), .rst(rstD), .in(inD), .eval(evalD), .out(outD), .armed(armedD), .dup_err(dupD));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1;
    inA = '0; inB = '0; inC = '0; inD = '0;
    evalA = 1'b0; evalB = 1'b0; evalC = 1'b0; evalD = 1'b0;
    tick();
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0; rstD = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rstA = 1'b1; inA = 2'b11; evalA = 1'b1;
    tick();
    rstA = 1'b0; inA = '0; evalA = 1'b0;
    total++; if (outA !== 1'b0) $display("[TB] FAIL reset_out got %b want 0", outA); else passed++;
    total++; if (armedA !== 2'b00) $display("[TB] FAIL reset_armed got %b want 00", armedA); else passed++;
    total++; if (dupA !== 1'b0) $display("[TB] FAIL reset_dup got %b want 0", dupA); else passed++;
    tick();
    total++; if (outA !== 1'b0) $display("[TB] FAIL reset_discard_eval got %b want 0", outA); else passed++;
  endtask

  task automatic test_and_pass();
    logic [1:0] model;
    logic       exp;
    reset_all();
    model = '0;
    for (int c = 0; c <= 9; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outA !== exp) $display("[TB] FAIL and_pass_out c=%0d got %b want %b", c, outA, exp); else passed++;
      total++; if (armedA !== model) $display("[TB] FAIL and_pass_armed c=%0d got %b want %b", c, armedA, model); else passed++;
      inA   = (c == 2) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      evalA = (c == 6);
      if (evalA) begin sb.push_back('{c + 1, &(model | inA)}); model = '0; end
      else model = model | inA;
      tick();
    end
    inA = '0; evalA = 1'b0;
  endtask

  task automatic test_and_fail();
    logic [1:0] model;
    logic       exp;
    reset_all();
    model = '0;
    for (int c = 0; c <= 11; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outA !== exp) $display("[TB] FAIL and_fail_out c=%0d got %b want %b", c, outA, exp); else passed++;
      total++; if (armedA !== model) $display("[TB] FAIL and_fail_armed c=%0d got %b want %b", c, armedA, model); else passed++;
      inA   = (c == 2) ? 2'b01 : 2'b00;
      evalA = (c == 5) || (c == 8);
      if (evalA) begin sb.push_back('{c + 1, &(model | inA)}); model = '0; end
      else model = model | inA;
      tick();
    end
    evalA = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] model;
    logic       exp;
    logic [1:0] ins [12];
    logic       evs [12];
    ins = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    evs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_all();
    model = '0;
    for (int c = 0; c < 12; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outA !== exp) $display("[TB] FAIL b2b_out c=%0d got %b want %b", c, outA, exp); else passed++;
      total++; if (armedA !== model) $display("[TB] FAIL b2b_armed c=%0d got %b want %b", c, armedA, model); else passed++;
      total++; if (dupA !== 1'b0) $display("[TB] FAIL b2b_merge_dup c=%0d got %b want 0", c, dupA); else passed++;
      inA   = ins[c];
      evalA = evs[c];
      if (evalA) begin sb.push_back('{c + 1, &(model | inA)}); model = '0; end
      else model = model | inA;
      tick();
    end
    inA = '0; evalA = 1'b0;
  endtask

  task automatic test_xor_parity();
    logic [3:0] model;
    logic       exp;
    reset_all();
    model = '0;
    for (int c = 0; c <= 15; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outB !== exp) $display("[TB] FAIL xor_out c=%0d got %b want %b", c, outB, exp); else passed++;
      total++; if (armedB !== model) $display("[TB] FAIL xor_armed c=%0d got %b want %b", c, armedB, model); else passed++;
      inB   = (c == 3) ? 4'b0011 : (c == 5) ? 4'b0001 : (c == 10) ? 4'b0111 : 4'b0000;
      evalB = (c == 3) || (c == 7) || (c == 10);
      if (evalB) begin sb.push_back('{c + 3, ^(model | inB)}); model = '0; end
      else model = model | inB;
      tick();
    end
    inB = '0; evalB = 1'b0;
  endtask

  task automatic test_or_consecutive();
    logic [1:0] model;
    logic       exp;
    reset_all();
    model = '0;
    for (int c = 0; c <= 8; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outC !== exp) $display("[TB] FAIL or_out c=%0d got %b want %b", c, outC, exp); else passed++;
      total++; if (armedC !== model) $display("[TB] FAIL or_armed c=%0d got %b want %b", c, armedC, model); else passed++;
      inC   = (c == 1) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
      evalC = (c == 3) || (c == 4);
      if (evalC) begin sb.push_back('{c + 2, |(model | inC)}); model = '0; end
      else model = model | inC;
      tick();
    end
    inC = '0; evalC = 1'b0;
  endtask

  task automatic test_dup_err();
    logic [1:0] expArmed;
    logic       expDup;
    reset_all();
    for (int c = 0; c <= 12; c++) begin
      expArmed = (c >= 3 && c <= 9) ? 2'b01 : (c == 12) ? 2'b10 : 2'b00;
      expDup   = (c >= 5 && c <= 9);
      total++; if (dupA !== expDup) $display("[TB] FAIL dup_flag c=%0d got %b want %b", c, dupA, expDup); else passed++;
      total++; if (armedA !== expArmed) $display("[TB] FAIL dup_armed c=%0d got %b want %b", c, armedA, expArmed); else passed++;
      total++; if (outA !== 1'b0) $display("[TB] FAIL dup_out c=%0d got %b want 0", c, outA); else passed++;
      rstA = (c == 9);
      inA  = (c == 2 || c == 4) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
      tick();
    end
    rstA = 1'b0; inA = '0;
  endtask

  task automatic test_reset_inflight();
    logic [1:0] model;
    logic       exp;
    reset_all();
    model = '0;
    for (int c = 0; c <= 26; c++) begin
      exp = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin exp = sb[0].val; void'(sb.pop_front()); end
      total++; if (outD !== exp) $display("[TB] FAIL inflight_out c=%0d got %b want %b", c, outD, exp); else passed++;
      total++; if (armedD !== model) $display("[TB] FAIL inflight_armed c=%0d got %b want %b", c, armedD, model); else passed++;
      rstD  = (c == 12);
      inD   = (c == 2 || c == 17) ? 2'b11 : 2'b00;
      evalD = (c == 10) || (c == 20);
      if (rstD) begin sb.delete(); model = '0; end
      else if (evalD) begin sb.push_back('{c + 4, &(model | inD)}); model = '0; end
      else model = model | inD;
      tick();
    end
    rstD = 1'b0; inD = '0; evalD = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_and_pass();
    test_and_fail();
    test_back_to_back();
    test_xor_parity();
    test_or_consecutive();
    test_dup_err();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
